mult32_seq_ctrl: RTL and testbench

MULT32_SEQ_CTRL -- requirements
Module: mult32_seq_ctrl

---
 rtl/mult32_seq_ctrl_pkg.sv | 6 +
 rtl/mult32_seq_ctrl_if.sv | 23 ++
 rtl/mult32_seq_ctrl_fsm.sv | 23 ++
 rtl/mult32_seq_ctrl.sv | 52 +++++
 tb/tb_mult32_seq_ctrl.sv | 98 +++++++++
 5 files changed

// File: rtl/mult32_seq_ctrl_pkg.sv
// mult32_seq_ctrl_pkg: shared constants and state encoding for the sequential multiplier and ALU
package mult_pkg;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam int ITER = 32;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/mult32_seq_ctrl_if.sv
// mult32_seq_ctrl_if: request/result and external adder signals of the sequential multiplier
interface mult32_seq_ctrl_if;
  logic start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic busy;
  logic done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic add_cin;
  logic [2:0] add_op;
  logic [31:0] add_res;
  logic add_cout;
  modport master(
    output start, multiplicand, multiplier, add_res, add_cout,
    input busy, done, product, add_a, add_b, add_cin, add_op
  );
  modport slave(
    input start, multiplicand, multiplier, add_res, add_cout,
    output busy, done, product, add_a, add_b, add_cin, add_op
  );
endinterface

// File: rtl/mult32_seq_ctrl_fsm.sv
// mult32_seq_fsm: state register, next-state and output decode of the shift-add multiplier
module mult32_seq_fsm
  import mult_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   last,
  output state_t state,
  output logic   busy,
  output logic   done
);
  state_t next;
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb
    next = state == IDLE  ? (start ? ADD : IDLE) :
           state == ADD   ? SHIFT :
           state == SHIFT ? (last ? DONE : ADD) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: rtl/mult32_seq_ctrl.sv
// mult32_seq_ctrl: 32x32 unsigned shift-add multiplier datapath driving an external 32-bit adder
module mult32_seq_ctrl
  import mult_pkg::*;
#(
  parameter logic [2:0] ALU_OP_ADD = mult_pkg::ALU_OP_ADD,
  parameter int ITER = mult_pkg::ITER
) (
  input logic clk,
  input logic reset,
  mult32_seq_ctrl_if.slave bus
);
  state_t state;
  logic [63:0] product;
  logic [31:0] mcand_reg;
  logic carry_reg;
  logic [5:0] count;
  logic last;
  assign last = count == 6'(ITER - 1);
  mult32_seq_fsm u_fsm (
    .clk(clk),
    .reset(reset),
    .start(bus.start),
    .last(last),
    .state(state),
    .busy(bus.busy),
    .done(bus.done)
  );
  always_ff @(posedge clk)
    if (reset) begin
      product <= '0;
      mcand_reg <= '0;
      carry_reg <= 1'b0;
      count <= '0;
    end else if (state == IDLE && bus.start) begin
      product <= {32'b0, bus.multiplier};
      mcand_reg <= bus.multiplicand;
      carry_reg <= 1'b0;
      count <= '0;
    end else if (state == ADD) begin
      if (product[0]) product[63:32] <= bus.add_res;
      carry_reg <= product[0] & bus.add_cout;
    end else if (state == SHIFT) begin
      product <= {carry_reg, product[63:1]};
      carry_reg <= 1'b0;
      count <= count + 6'd1;
    end
  assign bus.product = product;
  assign bus.add_a = product[63:32];
  assign bus.add_b = mcand_reg;
  assign bus.add_cin = 1'b0;
  assign bus.add_op = ALU_OP_ADD;
endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// tb_mult32_seq_ctrl: directed checks of latency, products, start masking and reset abort
module tb_mult32_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  mult32_seq_ctrl_if bus ();
  mult32_seq_ctrl dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign {bus.add_cout, bus.add_res} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int inj,
                         input logic [31:0] ia, input logic [31:0] ib);
    int lat;
    int busy_cnt;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    step();
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cnt++;
      if (lat == 5) check({tag, " add_b"}, {32'b0, bus.add_b}, {32'b0, a});
      bus.start = lat == inj;
      if (lat == inj) begin
        bus.multiplicand = ia;
        bus.multiplier = ib;
      end
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd65);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd64);
    check({tag, " product"}, bus.product, exp);
    step();
    check({tag, " done_pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
    check({tag, " product_hold"}, bus.product, exp);
  endtask
  initial begin
    int done_seen;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    check("reset product", bus.product, 64'd0);
    check("reset add_a_b", {bus.add_a, bus.add_b}, 64'd0);
    check("add_op_cin", {60'b0, bus.add_op, bus.add_cin}, 64'h4);
    step();
    check("idle no start", {62'b0, bus.busy, bus.done}, 64'd0);
    run_mul("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, '0, '0);
    run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, '0, '0);
    run_mul("zero", 32'd0, 32'h1234_5678, 64'd0, 0, '0, '0);
    run_mul("one", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 0, '0, '0);
    run_mul("restart", 32'd100, 32'd200, 64'h4E20, 10, 32'd7, 32'd9);
    run_mul("after_done", 32'd11, 32'd13, 64'd143, 0, '0, '0);
    bus.start = 1'b1;
    bus.multiplicand = 32'd123;
    bus.multiplier = 32'd456;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 29; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    check("abort product", bus.product, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.done) done_seen++;
      step();
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    run_mul("7x6", 32'd7, 32'd6, 64'd42, 0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
